// File: rtl/pll_ctl_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic phase-shift sequencer.
package pll_ctl_pkg;

  typedef enum logic [2:0] {
    LOCKWAIT,
    IDLE,
    SETUP,
    STEP_LO,
    STEP_HI,
    DONE
  } state_t;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  localparam logic DIR_LAG  = 1'b0;
  localparam logic DIR_LEAD = 1'b1;

endpackage

// File: rtl/pll_lock_sync.sv
// Synchronises the asynchronous PLL LOCK pin and qualifies it with a
// consecutive-lock counter so a bouncing lock never releases the sequencer.
module pll_lock_sync #(
  parameter int LOCK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic lk,
  output logic lock_stable
);

  localparam int CNT_W = $clog2(LOCK_CYC + 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], pll_locked};
      // Any unlocked cycle restarts the count; saturate once qualified.
      if (!sync_reg[1]) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_W'(LOCK_CYC)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign lk          = sync_reg[1];
  assign lock_stable = sync_reg[1] && (cnt_reg == CNT_W'(LOCK_CYC));

endmodule

// File: rtl/pll_phase_ctl.sv
// Sequences EHXPLLL PHASESEL/PHASEDIR/PHASESTEP for "shift output N by K steps"
// requests, tracks each output's phase position and aborts on lock loss.
module pll_phase_ctl
  import pll_ctl_pkg::*;
#(
  parameter int STEP_W     = 8,
  parameter int POS_W      = 4,
  parameter int POS_WRAP   = 8,
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CYC   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_sel,
  input  logic                 req_dir,
  input  logic [STEP_W-1:0]    req_steps,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           phasesel,
  output logic                 phasedir,
  output logic                 phasestep,
  output logic                 phaseloadreg,
  output logic [4*POS_W-1:0]   phase_pos
);

  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [STEP_W-1:0]   rem_reg;
  logic [1:0]          sel_reg;
  logic                dir_reg;
  logic                step_reg;
  logic                err_reg;
  logic                busy_reg;
  logic                lk, lock_stable;
  logic                accept, abort, step_event;

  pll_lock_sync #(.LOCK_CYC(LOCK_CYC)) u_lock_sync (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .lk          (lk),
    .lock_stable (lock_stable)
  );

  assign req_ready = (state_reg == IDLE) && lk;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    abort      = 1'b0;
    case (state_reg)
      LOCKWAIT: if (lock_stable) state_next = IDLE;
      IDLE: begin
        if (!lk)         state_next = LOCKWAIT;
        else if (accept) state_next = (req_steps == '0) ? DONE : SETUP;
      end
      SETUP:   if (cnt_reg == CNT_W'(SETUP_CYC - 1)) state_next = STEP_LO;
      STEP_LO: if (cnt_reg == CNT_W'(PULSE_CYC - 1)) state_next = STEP_HI;
      STEP_HI: if (cnt_reg == CNT_W'(SETTLE_CYC - 1))
                 state_next = (rem_reg != '0) ? STEP_LO : DONE;
      DONE:    state_next = IDLE;
      default: state_next = LOCKWAIT;
    endcase
    // Lock loss mid-operation overrides every other transition.
    if (!lk && state_reg != IDLE && state_reg != LOCKWAIT) begin
      state_next = LOCKWAIT;
      abort      = 1'b1;
    end
  end

  assign step_event = (state_reg == STEP_LO) && (state_next == STEP_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOCKWAIT;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      sel_reg   <= SEL_CLKOP;
      dir_reg   <= DIR_LEAD;
      step_reg  <= 1'b1;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)            cnt_reg <= '0;
      else if (cnt_reg != CNT_W'(MAX_CYC))    cnt_reg <= cnt_reg + 1'b1;
      if (accept) begin
        rem_reg <= req_steps;
        if (req_steps != '0) begin
          sel_reg <= req_sel;
          dir_reg <= req_dir;
        end
      end else if (step_event) begin
        rem_reg <= rem_reg - 1'b1;
      end
      step_reg <= (state_next != STEP_LO);
      err_reg  <= abort;
      busy_reg <= (state_next != IDLE);
    end
  end

  // Position advances on the PHASESTEP rising edge, i.e. entry to STEP_HI.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pos
      logic [POS_W-1:0] pos_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          pos_reg <= '0;
        end else if (step_event && sel_reg == 2'(gi)) begin
          if (dir_reg == DIR_LAG)
            pos_reg <= (pos_reg == POS_W'(POS_WRAP - 1)) ? '0 : pos_reg + 1'b1;
          else
            pos_reg <= (pos_reg == '0) ? POS_W'(POS_WRAP - 1) : pos_reg - 1'b1;
        end
      end
      assign phase_pos[gi*POS_W +: POS_W] = pos_reg;
    end
  endgenerate

  assign busy         = busy_reg;
  assign done         = (state_reg == DONE);
  assign err          = err_reg;
  assign phasesel     = sel_reg;
  assign phasedir     = dir_reg;
  assign phasestep    = step_reg;
  assign phaseloadreg = 1'b1;

endmodule

// File: tb/tb_pll_phase_ctl.sv
// Directed self-checking bench for pll_phase_ctl with hand-computed timings.
module tb_pll_phase_ctl;

  localparam int STEP_W = 8;
  localparam int POS_W  = 4;
  localparam int PULSE  = 4;
  localparam int SETTLE = 8;

  logic clk = 1'b0;
  logic rst, pll_locked, req_valid, req_ready, req_dir;
  logic [1:0] req_sel;
  logic [STEP_W-1:0] req_steps;
  logic busy, done, err, phasedir, phasestep, phaseloadreg;
  logic [1:0] phasesel;
  logic [4*POS_W-1:0] phase_pos;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pll_phase_ctl dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps), .busy(busy), .done(done),
    .err(err), .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .phase_pos(phase_pos)
  );

  function automatic logic [POS_W-1:0] pos_of(input int s);
    return phase_pos[s*POS_W +: POS_W];
  endfunction

  // Issues one request and monitors it; returns observations, checks nothing.
  task automatic do_req(input logic [1:0] s, input logic d, input logic [STEP_W-1:0] n,
                        input int budget, output int done_at, output int err_at,
                        output int n_pulses, output int first_lo, output int bad_lo,
                        output int bad_hi, output int sel_bad, output logic ready1);
    int lo_len, hi_len;
    logic prev;
    done_at = -1; err_at = -1; n_pulses = 0; first_lo = -1;
    bad_lo = 0; bad_hi = 0; sel_bad = 0; ready1 = 1'bx;
    for (int w = 0; w < 100 && !req_ready; w++) @(negedge clk);
    if (!req_ready) return;
    req_sel = s; req_dir = d; req_steps = n; req_valid = 1'b1;
    prev = 1'b1; lo_len = 0; hi_len = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) begin
        ready1 = req_ready;
        req_valid = 1'b0;
      end
      if (phasestep === 1'b0) begin
        if (prev) begin
          n_pulses++;
          if (n_pulses == 1) first_lo = i;
          else if (hi_len != SETTLE) bad_hi++;
        end
        lo_len++;
        prev = 1'b0;
      end else begin
        if (!prev) begin
          if (lo_len != PULSE) bad_lo++;
          lo_len = 0;
          hi_len = 0;
        end
        hi_len++;
        prev = 1'b1;
      end
      if (n != 0 && phasesel !== s) sel_bad++;
      if (err === 1'b1) begin err_at = i; break; end
      if (done === 1'b1) begin done_at = i; break; end
    end
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1; pll_locked = 1'b1; req_valid = 1'b0;
    req_sel = '0; req_dir = 1'b0; req_steps = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (phasestep !== 1'b1) begin n_bad++; $display("FAIL rst_phasestep: got %b want 1", phasestep); end
    n_vec++; if (phasedir !== 1'b1) begin n_bad++; $display("FAIL rst_phasedir: got %b want 1", phasedir); end
    n_vec++; if (phasesel !== 2'd0) begin n_bad++; $display("FAIL rst_phasesel: got %0d want 0", phasesel); end
    n_vec++; if (phaseloadreg !== 1'b1) begin n_bad++; $display("FAIL rst_loadreg: got %b want 1", phaseloadreg); end
    n_vec++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: busy/done/err got %b want 000", {busy, done, err}); end
    n_vec++; if (phase_pos !== '0) begin n_bad++; $display("FAIL rst_pos: got %h want 0", phase_pos); end
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lockwait_busy: got %b want 1", busy); end
    k = 1;
    while (req_ready !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    // 2 synchroniser flops + 16 counted cycles + 1 state register
    n_vec++; if (k != 19) begin n_bad++; $display("FAIL lock_release: ready after %0d cycles want 19", k); end
    $display("reset: ready after %0d cycles", k);
  endtask

  task automatic test_basic();
    int da, ea, np, fl, bl, bh, sb;
    logic r1;
    do_req(2'd2, 1'b0, 8'd3, 100, da, ea, np, fl, bl, bh, sb, r1);
    n_vec++; if (da != 41) begin n_bad++; $display("FAIL basic_latency: done at %0d want 41", da); end
    n_vec++; if (ea != -1) begin n_bad++; $display("FAIL basic_err: err at %0d want none", ea); end
    n_vec++; if (np != 3) begin n_bad++; $display("FAIL basic_pulses: got %0d want 3", np); end
    n_vec++; if (fl != 5) begin n_bad++; $display("FAIL basic_first_lo: got %0d want 5", fl); end
    n_vec++; if (bl != 0 || bh != 0) begin n_bad++; $display("FAIL basic_shape: bad_lo %0d bad_hi %0d want 0 0", bl, bh); end
    n_vec++; if (sb != 0) begin n_bad++; $display("FAIL basic_sel: %0d cycles with phasesel!=2 want 0", sb); end
    n_vec++; if (pos_of(2) !== 4'd3) begin n_bad++; $display("FAIL basic_pos: got %0d want 3", pos_of(2)); end
    $display("basic: sel=2 dir=0 steps=3 done@%0d pulses=%0d pos2=%0d", da, np, pos_of(2));
  endtask

  task automatic test_wrap();
    int da, ea, np, fl, bl, bh, sb;
    logic r1;
    do_req(2'd0, 1'b1, 8'd1, 60, da, ea, np, fl, bl, bh, sb, r1);
    n_vec++; if (da != 17) begin n_bad++; $display("FAIL wrap_lead_latency: done at %0d want 17", da); end
    n_vec++; if (pos_of(0) !== 4'd7) begin n_bad++; $display("FAIL wrap_lead_pos: got %0d want 7", pos_of(0)); end
    $display("wrap lead: sel=0 steps=1 done@%0d pos0=%0d", da, pos_of(0));
    do_req(2'd0, 1'b0, 8'd9, 200, da, ea, np, fl, bl, bh, sb, r1);
    n_vec++; if (da != 113) begin n_bad++; $display("FAIL wrap_lag_latency: done at %0d want 113", da); end
    n_vec++; if (np != 9) begin n_bad++; $display("FAIL wrap_lag_pulses: got %0d want 9", np); end
    n_vec++; if (pos_of(0) !== 4'd0) begin n_bad++; $display("FAIL wrap_lag_pos: got %0d want 0", pos_of(0)); end
    $display("wrap lag: sel=0 steps=9 done@%0d pos0=%0d", da, pos_of(0));
  endtask

  task automatic test_zero_steps();
    int da, ea, np, fl, bl, bh, sb;
    logic r1;
    do_req(2'd3, 1'b1, 8'd0, 20, da, ea, np, fl, bl, bh, sb, r1);
    n_vec++; if (da != 1) begin n_bad++; $display("FAIL zero_done: done at %0d want 1", da); end
    n_vec++; if (r1 !== 1'b0) begin n_bad++; $display("FAIL zero_ready_drop: got %b want 0", r1); end
    n_vec++; if (np != 0) begin n_bad++; $display("FAIL zero_pulses: got %0d want 0", np); end
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready_back: got %b want 1", req_ready); end
    n_vec++; if (phase_pos !== 16'h0300) begin n_bad++; $display("FAIL zero_pos: got %h want 0300", phase_pos); end
    n_vec++; if ({phasesel, phasedir} !== 3'b000) begin n_bad++; $display("FAIL zero_seldir: got %b want 000", {phasesel, phasedir}); end
    $display("zero steps: done@%0d ready1=%b pos=%h", da, r1, phase_pos);
  endtask

  task automatic test_lock_loss();
    int falls, err_cnt, done_cnt, first_ready;
    logic prev, ps3;
    for (int w = 0; w < 100 && !req_ready; w++) @(negedge clk);
    req_sel = 2'd1; req_dir = 1'b0; req_steps = 8'd5; req_valid = 1'b1;
    falls = 0; prev = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      if (phasestep === 1'b0 && prev) falls++;
      prev = phasestep;
      if (falls == 2) break;
    end
    pll_locked = 1'b0;
    err_cnt = 0; done_cnt = 0; ps3 = 1'bx;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 3) ps3 = phasestep;
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    n_vec++; if (falls != 2) begin n_bad++; $display("FAIL loss_reach_pulse2: saw %0d pulses want 2", falls); end
    n_vec++; if (ps3 !== 1'b1) begin n_bad++; $display("FAIL loss_phasestep: got %b want 1 at 3 cycles", ps3); end
    n_vec++; if (err_cnt != 1) begin n_bad++; $display("FAIL loss_err: %0d err pulses want 1", err_cnt); end
    n_vec++; if (done_cnt != 0) begin n_bad++; $display("FAIL loss_done: %0d done pulses want 0", done_cnt); end
    n_vec++; if (pos_of(1) !== 4'd1) begin n_bad++; $display("FAIL loss_pos: got %0d want 1", pos_of(1)); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL loss_busy: got %b want 1", busy); end
    pll_locked = 1'b1;
    first_ready = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1 && first_ready < 0) first_ready = k;
    end
    n_vec++; if (first_ready != 19) begin n_bad++; $display("FAIL loss_relock: ready after %0d want 19", first_ready); end
    $display("lock loss: err=%0d done=%0d pos1=%0d relock ready@%0d", err_cnt, done_cnt, pos_of(1), first_ready);
  endtask

  task automatic test_back_to_back();
    int acc[4], dn[4];
    int n_acc, n_done;
    for (int w = 0; w < 100 && !req_ready; w++) @(negedge clk);
    foreach (acc[x]) begin acc[x] = -1; dn[x] = -1; end
    n_acc = 0; n_done = 0;
    req_sel = 2'd3; req_dir = 1'b0; req_steps = 8'd2; req_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (done === 1'b1) begin
        if (n_done < 4) dn[n_done] = i;
        n_done++;
      end
      if (req_valid && req_ready === 1'b1) begin
        if (n_acc < 4) acc[n_acc] = i;
        n_acc++;
        @(posedge clk);
        #1;
        if (n_acc == 1) begin req_sel = 2'd3; req_dir = 1'b1; req_steps = 8'd1; end
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_vec++; if (n_acc != 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 2", n_acc); end
    n_vec++; if (n_done != 2) begin n_bad++; $display("FAIL b2b_dones: got %0d want 2", n_done); end
    n_vec++; if (dn[0] - acc[0] != 29) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 29", dn[0] - acc[0]); end
    n_vec++; if (acc[1] != dn[0] + 1) begin n_bad++; $display("FAIL b2b_second_accept: at %0d want %0d", acc[1], dn[0] + 1); end
    n_vec++; if (dn[1] - acc[1] != 17) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 17", dn[1] - acc[1]); end
    n_vec++; if (pos_of(3) !== 4'd1) begin n_bad++; $display("FAIL b2b_pos: got %0d want 1", pos_of(3)); end
    $display("back-to-back: acc=%0d,%0d done=%0d,%0d pos3=%0d", acc[0], acc[1], dn[0], dn[1], pos_of(3));
  endtask

  task automatic test_rst_mid_op();
    logic hit;
    for (int w = 0; w < 100 && !req_ready; w++) @(negedge clk);
    req_sel = 2'd2; req_dir = 1'b0; req_steps = 8'd4; req_valid = 1'b1;
    hit = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      if (phasestep === 1'b0) begin hit = 1'b1; break; end
    end
    n_vec++; if (hit !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_lo: got %b want 1", hit); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (phasestep !== 1'b1) begin n_bad++; $display("FAIL rstmid_phasestep: got %b want 1", phasestep); end
    n_vec++; if (phase_pos !== '0) begin n_bad++; $display("FAIL rstmid_pos: got %h want 0", phase_pos); end
    n_vec++; if ({done, err} !== 2'b00) begin n_bad++; $display("FAIL rstmid_flags: done/err got %b want 00", {done, err}); end
    n_vec++; if ({phasesel, phasedir} !== 3'b001) begin n_bad++; $display("FAIL rstmid_seldir: got %b want 001", {phasesel, phasedir}); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    n_vec++; if ({phasestep, done, err} !== 3'b100) begin n_bad++; $display("FAIL rstmid_after: step/done/err got %b want 100", {phasestep, done, err}); end
    $display("reset mid-op: phasestep=%b busy=%b pos=%h", phasestep, busy, phase_pos);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_steps();
    test_lock_loss();
    test_back_to_back();
    test_rst_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
